mdu_issue_ctrl: RTL and testbench

MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

---
 rtl/mdu_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// Issue controller for the multiply/divide unit: starts MD ops, tracks their busy window and stalls
// HI/LO consumers in D. Optional stall-cycle counter when MDU_STALL_CNT_EN is defined.
module mdu_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [3:0]  d_op,
  output logic        start,
  output logic [3:0]  mdu_op,
  output logic        mt_we,
  output logic        busy,
  output logic        stall,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  logic [3:0] e_op_eff;
  logic       e_is_md;
  logic       e_is_mt;
  logic       d_is_hilo;
  logic       issue_ok;

  // Undefined encodings behave exactly like "no op".
  assign e_op_eff  = (e_op > OP_MTLO) ? OP_NONE : e_op;
  assign e_is_md   = (e_op_eff >= OP_MULT) && (e_op_eff <= OP_DIVU);
  assign e_is_mt   = (e_op_eff == OP_MTHI) || (e_op_eff == OP_MTLO);
  assign d_is_hilo = (d_op >= OP_MULT) && (d_op <= OP_MTLO);

  // reset is folded in so the combinational outputs are quiet while reset is held.
  assign issue_ok  = reset & e_valid & ~req;

  assign start  = issue_ok & e_is_md & (state_q == IDLE);
  assign mdu_op = issue_ok ? e_op_eff : OP_NONE;
  assign mt_we  = issue_ok & e_is_mt & (state_q == IDLE);
  assign busy   = busy_q;
  assign stall  = reset & (start | busy_q) & d_is_hilo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          busy_d  = 1'b1;
          cnt_d   = ((e_op_eff == OP_MULT) || (e_op_eff == OP_MULTU)) ? MULT_LD : DIV_LD;
        end
      end
      BUSY: begin
        // req is deliberately ignored here: an issued MD op always runs to completion.
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MDU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d  = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
  assign stall_cycles = stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed scoreboard bench for mdu_issue_ctrl: each driven cycle queues its expected outputs,
// and a negedge monitor pops and compares them.
module tb_mdu_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        req;
  logic        e_valid;
  logic [3:0]  e_op;
  logic [3:0]  d_op;
  logic        start;
  logic [3:0]  mdu_op;
  logic        mt_we;
  logic        busy;
  logic        stall;
  logic [31:0] stall_cycles;

  mdu_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .e_valid      (e_valid),
    .e_op         (e_op),
    .d_op         (d_op),
    .start        (start),
    .mdu_op       (mdu_op),
    .mt_we        (mt_we),
    .busy         (busy),
    .stall        (stall),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        st;
    logic [3:0]  op;
    logic        mt;
    logic        bsy;
    logic        stl;
    logic [31:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          step_id = 0;
  logic [31:0] exp_sc = 32'd0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s step %0d actual=%0h required=%0h", name, id, act, req_v);
    end
  endtask

  // Monitor: outputs are presented every cycle, so one expectation is consumed per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("start",        e.id, {31'd0, start}, {31'd0, e.st});
      chk("mdu_op",       e.id, {28'd0, mdu_op}, {28'd0, e.op});
      chk("mt_we",        e.id, {31'd0, mt_we}, {31'd0, e.mt});
      chk("busy",         e.id, {31'd0, busy}, {31'd0, e.bsy});
      chk("stall",        e.id, {31'd0, stall}, {31'd0, e.stl});
      chk("stall_cycles", e.id, stall_cycles, e.sc);
    end
  end

  // Called just after a rising edge: drive one cycle of inputs, queue what that cycle must show.
  task automatic step(input logic rst, input logic ev, input logic [3:0] op, input logic [3:0] dop,
                      input logic rq, input logic x_st, input logic [3:0] x_op, input logic x_mt,
                      input logic x_bsy, input logic x_stl);
    exp_t e;
    reset   = rst;
    e_valid = ev;
    e_op    = op;
    d_op    = dop;
    req     = rq;
    if (!rst) exp_sc = 32'd0;
    e.id  = step_id;
    e.st  = x_st;
    e.op  = x_op;
    e.mt  = x_mt;
    e.bsy = x_bsy;
    e.stl = x_stl;
    e.sc  = exp_sc;
    exp_q.push_back(e);
`ifdef MDU_STALL_CNT_EN
    if (x_stl) exp_sc = exp_sc + 32'd1;
`endif
    step_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step %0d actual=timeout required=finish", step_id);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    req     = 1'b0;
    e_valid = 1'b0;
    e_op    = 4'd0;
    d_op    = 4'd0;
    @(posedge clk);
    #1;

    // Held in reset with a live mult and HI/LO reader: everything quiet.
    step(0, 1, 4'd1, 4'd5, 0,  0, 4'd0, 0, 0, 0);

    // mult out of reset: start now, busy for 5 cycles, idle after.
    step(1, 1, 4'd1, 4'd0, 0,  1, 4'd1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 4'd0, 4'd0, 0,  0, 4'd0, 0, 1, 0);
    step(1, 0, 4'd0, 4'd0, 0,  0, 4'd0, 0, 0, 0);

    // div with mfhi held in D: 11 stall cycles total.
    step(1, 1, 4'd3, 4'd5, 0,  1, 4'd3, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 4'd0, 4'd5, 0,  0, 4'd0, 0, 1, 1);
    step(1, 0, 4'd0, 4'd5, 0,  0, 4'd0, 0, 0, 0);

    // mult colliding with req: no issue, no state change.
    step(1, 1, 4'd1, 4'd5, 1,  0, 4'd0, 0, 0, 0);
    step(1, 0, 4'd0, 4'd0, 0,  0, 4'd0, 0, 0, 0);

    // divu, req (with a div in E) on busy cycle 3 does not abort the count.
    step(1, 1, 4'd4, 4'd0, 0,  1, 4'd4, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) step(1, 1, 4'd3, 4'd0, 1,  0, 4'd0, 0, 1, 0);
      else        step(1, 0, 4'd0, 4'd0, 0,  0, 4'd0, 0, 1, 0);
    end
    step(1, 0, 4'd0, 4'd0, 0,  0, 4'd0, 0, 0, 0);

    // Idle non-MD ops: mthi writes, undefined op is inert, mflo forwards, req blocks mtlo.
    step(1, 1, 4'd7, 4'd0, 0,  0, 4'd7, 1, 0, 0);
    step(1, 1, 4'd9, 4'd0, 0,  0, 4'd0, 0, 0, 0);
    step(1, 1, 4'd6, 4'd1, 0,  0, 4'd6, 0, 0, 0);
    step(1, 1, 4'd8, 4'd0, 1,  0, 4'd0, 0, 0, 0);

    // mult, then mtlo and a div arrive while busy; d_op 9 is not a HI/LO reader.
    step(1, 1, 4'd1, 4'd2, 0,  1, 4'd1, 0, 0, 1);
    step(1, 1, 4'd8, 4'd0, 0,  0, 4'd8, 0, 1, 0);
    step(1, 1, 4'd3, 4'd0, 0,  0, 4'd3, 0, 1, 0);
    step(1, 0, 4'd0, 4'd9, 0,  0, 4'd0, 0, 1, 0);
    step(1, 0, 4'd0, 4'd8, 0,  0, 4'd0, 0, 1, 1);
    step(1, 0, 4'd0, 4'd0, 0,  0, 4'd0, 0, 1, 0);
    step(1, 0, 4'd0, 4'd0, 0,  0, 4'd0, 0, 0, 0);

    // multu, reset pulsed on busy cycle 2: abandoned, never completes.
    step(1, 1, 4'd2, 4'd0, 0,  1, 4'd2, 0, 0, 0);
    step(1, 0, 4'd0, 4'd5, 0,  0, 4'd0, 0, 1, 1);
    step(0, 1, 4'd2, 4'd5, 0,  0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 4'd0, 4'd5, 0,  0, 4'd0, 0, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain step %0d actual=%0d required=0", step_id, exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
